data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the RV32 core. It services the executor's load/store requests (`address`, `write_data`, `read_data_sig`, `write_data_sig`) from an internal word-organised RAM. It returns lane-aligned `read_data` and holds the core with `wait_sig` for a configurable access latency. It sits between the executor and the data RAM and is the memory-side end of the executor's load/store interface.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words (power of two).
- `LATENCY`, 2: cycles `wait_sig` stays high per access (legal range 1..15).
- `ADDR_BASE`, 32'h0000_0000: byte address of word 0.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `address` input 32: byte address from the executor.
- `write_data` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `read_data_sig` input 1: load request.
- `write_data_sig` input 1: store request.
- `mem_size` input 3: funct3 of the access (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `read_data` output 32: load result, right-justified, upper bits zero.
- `wait_sig` output 1: stall request to the executor.
- `mem_err` output 1: access error, valid in the DONE cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - With `read_data_sig` or `write_data_sig` high, the request is accepted.
  - At accept, the block latches `address`, `write_data`, `mem_size` and the request kind, and loads `cnt = LATENCY-1`.
  - Next state is DONE when `LATENCY == 1`, otherwise BUSY.
- **BUSY**: `cnt` decrements each cycle; the FSM moves to DONE on the edge where `cnt == 0`.
- **Entering DONE** (single edge). The RAM access uses the latched request only:
  - Store: writes the byte lanes selected by `addr[1:0]` and size.
    - B writes lane `addr[1:0]` with data[7:0].
    - H writes lanes `{addr[1],0}` and `{addr[1],1}` with data[15:0].
    - W writes all four lanes.
  - Load: `read_data` is loaded with the selected lane(s), shifted down to bit 0 and zero-filled above. BU/HU are identical to B/H; the executor performs sign extension.
- **DONE**: lasts one cycle, then the FSM returns to IDLE unconditionally. A request present in the following IDLE cycle is a new access.
- Input changes after accept are ignored.
- **Errors.** Each error sets `mem_err = 1` in DONE, suppresses the store, and makes a load return 0.
  - Word offset `(address - ADDR_BASE) >> 2` is ≥ DEPTH.
  - `read_data_sig` and `write_data_sig` are both high; this is treated as a store.
  - Invalid `mem_size` (011, 110, 111).
  - Misaligned access, only when `DMEM_MISALIGN_TRAP_EN` is defined (see Configuration).
- **Reset** (any time, including mid-BUSY):
  - FSM goes to IDLE, `cnt` to 0.
  - `read_data` = 0, `mem_err` = 0, `wait_sig` = 0.
  - Pending store is dropped; RAM contents are not cleared.

## Timing
- `wait_sig` is combinational: `(IDLE && (read_data_sig || write_data_sig)) || BUSY`. It is 0 in DONE and forced 0 while `rst_n` = 0.
- Request first seen in cycle T: `wait_sig` is high in T..T+LATENCY-1; DONE is cycle T+LATENCY. Each memory instruction therefore occupies LATENCY+1 cycles.
- `read_data` and `mem_err` are registered and valid in the DONE cycle.
  - `read_data` holds its value until the next completed load.
  - `mem_err` returns to 0 on leaving DONE.
- Store commit happens at the edge entering DONE.
- Back-to-back accesses: DONE at cycle D, the next request is accepted at D+1, with no gap beyond the DONE cycle.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- **Defined**: the following are errors (`mem_err = 1`, no store, load returns 0):
  - H/HU with `addr[0] = 1`.
  - W with `addr[1:0] != 0`.
- **Undefined**: misaligned addresses are forced to alignment (`addr[0]` cleared for H, `addr[1:0]` cleared for W), and the access completes without error.

## Structure
- Package `dmem_pkg`:
  - Size codes `SZ_B = 3'b000`, `SZ_H = 3'b001`, `SZ_W = 3'b010`, `SZ_BU = 3'b100`, `SZ_HU = 3'b101`.
  - FSM state encoding constants IDLE/BUSY/DONE.
- Sub-module `dmem_ram`:
  - DEPTH × 32 with a 4-bit byte-enable write port and a synchronous read port.
  - One access per cycle, driven by the FSM on the DONE-entry edge.
  - Lane shifting and error checks stay in the parent.

## Test plan
- **Latency and word round-trip** (LATENCY=2): store W 0xDEADBEEF to 0x10, then load W from 0x10.
  - `wait_sig` is high 2 cycles for each access.
  - The load's DONE cycle shows `read_data = 0xDEADBEEF`, `mem_err = 0`.
- **Byte and half lanes**:
  - SB 0xAA to 0x21, then LW 0x20 → 0x0000AA00 (word previously 0).
  - SH 0x1234 to 0x22, then LHU 0x22 → 0x00001234.
  - LB 0x21 → 0x000000AA.
- **Out of range** (DEPTH=1024): SW to 0x1000 → `mem_err = 1`, RAM unchanged; LW 0x1000 → `read_data = 0`, `mem_err = 1`.
- **Misaligned**: LW from 0x22 with the macro defined → `mem_err = 1`, `read_data = 0`. Without the macro → data of word 0x20, `mem_err = 0`.
- **Reset mid-access**: SW 0x55 to 0x30, assert `rst_n = 0` in BUSY.
  - All outputs go to 0, state is IDLE.
  - A later LW 0x30 returns the old value (store dropped).
- **Back-to-back and protocol**:
  - LATENCY=1: two consecutive loads complete in 4 cycles total.
  - Both strobes high → store performed as error: no write, `mem_err = 1`.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared size codes, FSM states and helpers for the data-memory responder.
// Pure definitions: no logic, no latency, no flow control.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic size_ok(input logic [2:0] sz);
        case (sz)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_ok = 1'b1;
            default:                        size_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: byte-enable write port and registered read port.
// Latency: write commits at the clock edge; read data appears after one edge.
// Backpressure: none; the caller issues at most one access per cycle.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    i_be,
    input  logic          i_re,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    // The read register only moves on a load, so it doubles as the load-result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the RV32 executor; DMEM_MISALIGN_TRAP_EN turns misalignment into an error.
// Latency: wait_sig high LATENCY cycles, result/mem_err valid in the following DONE cycle.
// Backpressure: wait_sig stalls the executor; requests are only accepted in IDLE.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        read_data_sig,
    input  logic        write_data_sig,
    input  logic [2:0]  mem_size,
    output logic [31:0] read_data,
    output logic        wait_sig,
    output logic        mem_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_size;
    logic        r_store, r_both, r_err;
    logic [1:0]  r_rd_lane, r_rd_sz;
    logic        r_rd_zero;

    logic        w_req, w_idle, w_go, w_err, w_st, w_bo, w_mis_err;
    logic [31:0] w_addr, w_wd, w_off, w_wrep, w_ram_q, w_sh;
    logic [2:0]  w_sz;
    logic [1:0]  w_lane;
    logic [3:0]  w_be_raw, w_be;

    assign w_req  = read_data_sig | write_data_sig;
    assign w_idle = (r_state == IDLE);
    assign w_go   = rst_n & ((w_idle & w_req & (LATENCY == 1)) |
                             ((r_state == BUSY) & (r_cnt == 4'd1)));

    // With LATENCY==1 the access happens on the accept edge, so use the live inputs there.
    assign w_addr = w_idle ? address        : r_addr;
    assign w_wd   = w_idle ? write_data     : r_wdata;
    assign w_sz   = w_idle ? mem_size       : r_size;
    assign w_st   = w_idle ? write_data_sig : r_store;
    assign w_bo   = w_idle ? (read_data_sig & write_data_sig) : r_both;
    assign w_off  = w_addr - ADDR_BASE;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis_err = ((w_sz[1:0] == 2'b01) & w_off[0]) |
                       ((w_sz[1:0] == 2'b10) & (w_off[1:0] != 2'b00));
    assign w_lane    = w_off[1:0];
`else
    assign w_mis_err = 1'b0;
    assign w_lane    = (w_sz[1:0] == 2'b01) ? {w_off[1], 1'b0} :
                       (w_sz[1:0] == 2'b10) ? 2'b00 : w_off[1:0];
`endif

    assign w_err = (w_off[31:2] >= 30'(DEPTH)) | w_bo | ~size_ok(w_sz) | w_mis_err;

    always_comb begin
        w_be_raw = 4'b1111;
        w_wrep   = w_wd;
        case (w_sz[1:0])
            2'b00: begin
                w_be_raw = 4'b0001 << w_lane;
                w_wrep   = {4{w_wd[7:0]}};
            end
            2'b01: begin
                w_be_raw = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wrep   = {2{w_wd[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_be = (w_go & w_st & ~w_err) ? w_be_raw : 4'b0000;

    dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_be    (w_be),
        .i_re    (w_go & ~w_st & ~w_err),
        .i_idx   (w_off[AW+1:2]),
        .i_wdata (w_wrep),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_store   <= 1'b0;
            r_both    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_lane <= 2'b00;
            r_rd_sz   <= 2'b00;
            r_rd_zero <= 1'b1;
        end else begin
            r_err <= w_go ? w_err : 1'b0;
            if (w_go && !w_st) begin
                r_rd_lane <= w_lane;
                r_rd_sz   <= w_sz[1:0];
                r_rd_zero <= w_err;
            end
            case (r_state)
                IDLE: if (w_req) begin
                    r_addr  <= address;
                    r_wdata <= write_data;
                    r_size  <= mem_size;
                    r_store <= write_data_sig;
                    r_both  <= read_data_sig & write_data_sig;
                    r_cnt   <= CNT_INIT;
                    r_state <= (LATENCY == 1) ? DONE : BUSY;
                end
                // Leave BUSY on the edge where the count reaches zero.
                BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_sh = w_ram_q >> {r_rd_lane, 3'b000};

    always_comb begin
        read_data = w_ram_q;
        case (r_rd_sz)
            2'b00:   read_data = {24'd0, w_sh[7:0]};
            2'b01:   read_data = {16'd0, w_sh[15:0]};
            default: ;
        endcase
        if (r_rd_zero) read_data = 32'd0;
    end

    assign mem_err  = r_err;
    assign wait_sig = rst_n & ((w_idle & w_req) | (r_state == BUSY));

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and random load/store traffic against a byte-array model of the responder.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0, write_data = '0, read_data;
    logic        rd = 1'b0, wr = 1'b0, wait_sig, mem_err;
    logic [2:0]  mem_size = '0;

    logic [31:0] a1 = '0, wd1 = '0, q1;
    logic        rd1 = 1'b0, wr1 = 1'b0, w1, e1;
    logic [2:0]  sz1 = '0;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mref [0:4*DEPTH-1];
    logic [31:0] exp_rd = '0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_BASE(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .read_data_sig(rd), .write_data_sig(wr), .mem_size(mem_size),
        .read_data(read_data), .wait_sig(wait_sig), .mem_err(mem_err)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .ADDR_BASE(32'h0)) u1 (
        .clk(clk), .rst_n(rst_n), .address(a1), .write_data(wd1),
        .read_data_sig(rd1), .write_data_sig(wr1), .mem_size(sz1),
        .read_data(q1), .wait_sig(w1), .mem_err(e1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory viewed as little-endian bytes; misaligned accesses round down unless trapping.
    task automatic ref_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] sz, output logic err);
        logic [31:0] off, v;
        int n;
        off = a;
        err = 1'b0;
        if (off / 4 >= DEPTH) err = 1'b1;
        if (r && w) err = 1'b1;
        n = (sz == SZ_B || sz == SZ_BU) ? 1 : (sz == SZ_H || sz == SZ_HU) ? 2 : (sz == SZ_W) ? 4 : 0;
        if (n == 0) err = 1'b1;
        if (n > 0 && (off % n) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            err = 1'b1;
`else
            off = off - (off % n);
`endif
        end
        if (w) begin
            if (!err) for (int i = 0; i < n; i++) mref[off + i] = 8'(d >> (8 * i));
        end else begin
            v = '0;
            if (!err) for (int i = 0; i < n; i++) v = v | (32'(mref[off + i]) << (8 * i));
            exp_rd = v;
        end
    endtask

    // Called and returns just after a falling edge.
    task automatic access(input string tag, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] sz);
        int  n;
        logic e;
        ref_access(r, w, a, d, sz, e);
        address = a; write_data = d; mem_size = sz; rd = r; wr = w;
        #1;
        n = 0;
        while (wait_sig === 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
        check({tag, "_lat"}, n, LAT);
        check({tag, "_err"}, 32'(mem_err), 32'(e));
        check({tag, "_rd"}, read_data, exp_rd);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk); #1;
        check({tag, "_errclr"}, 32'(mem_err), 32'd0);
    endtask

    initial begin
        logic        r, w;
        logic [31:0] a;
        logic [2:0]  sz;

        for (int i = 0; i < 4 * DEPTH; i++) mref[i] = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check("rst_wait", 32'(wait_sig), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 64; i++) access("init", 1'b0, 1'b1, 32'(i * 4), 32'd0, SZ_W);

        access("sw_dead", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_W);
        access("lw_dead", 1'b1, 1'b0, 32'h10, 32'h0, SZ_W);
        check("lw_dead_lit", read_data, 32'hDEADBEEF);

        access("sb_21", 1'b0, 1'b1, 32'h21, 32'h000000AA, SZ_B);
        access("lw_20", 1'b1, 1'b0, 32'h20, 32'h0, SZ_W);
        check("lw_20_lit", read_data, 32'h0000AA00);
        access("sh_22", 1'b0, 1'b1, 32'h22, 32'h00001234, SZ_H);
        access("lhu_22", 1'b1, 1'b0, 32'h22, 32'h0, SZ_HU);
        check("lhu_22_lit", read_data, 32'h00001234);
        access("lb_21", 1'b1, 1'b0, 32'h21, 32'h0, SZ_B);
        check("lb_21_lit", read_data, 32'h000000AA);

        access("sw_oor", 1'b0, 1'b1, 32'h1000, 32'h12345678, SZ_W);
        access("lw_oor", 1'b1, 1'b0, 32'h1000, 32'h0, SZ_W);
        check("lw_oor_lit", read_data, 32'h0);
        access("lw_0_after_oor", 1'b1, 1'b0, 32'h0, 32'h0, SZ_W);

        access("lw_mis", 1'b1, 1'b0, 32'h22, 32'h0, SZ_W);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw_mis_lit", read_data, 32'h0);
`else
        check("lw_mis_lit", read_data, 32'h1234AA00);
`endif

        access("both", 1'b1, 1'b1, 32'h40, 32'h77, SZ_W);
        access("lw_40", 1'b1, 1'b0, 32'h40, 32'h0, SZ_W);
        access("badsz", 1'b1, 1'b0, 32'h10, 32'h0, 3'b011);

        // Reset while a store is in BUSY: store must be dropped.
        access("sw_30", 1'b0, 1'b1, 32'h30, 32'h11223344, SZ_W);
        address = 32'h30; write_data = 32'h55; mem_size = SZ_W; wr = 1'b1;
        #1;
        check("mid_wait_t0", 32'(wait_sig), 32'd1);
        @(negedge clk); #1;
        check("mid_wait_busy", 32'(wait_sig), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wait", 32'(wait_sig), 32'd0);
        check("mid_rst_rdata", read_data, 32'd0);
        check("mid_rst_err", 32'(mem_err), 32'd0);
        wr = 1'b0;
        exp_rd = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_idle", 32'(wait_sig), 32'd0);
        access("lw_30", 1'b1, 1'b0, 32'h30, 32'h0, SZ_W);
        check("lw_30_lit", read_data, 32'h11223344);

        repeat (60) begin
            r  = 1'($urandom_range(0, 1));
            w  = ~r;
            if ($urandom_range(0, 15) == 0) begin r = 1'b1; w = 1'b1; end
            a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 8191) : 32'($urandom_range(0, 255));
            sz = 3'($urandom_range(0, 7));
            access("rnd", r, w, a, $urandom, sz);
        end

        // LATENCY=1 instance: back-to-back stores then two loads in four cycles.
        wr1 = 1'b1; a1 = 32'h0; wd1 = 32'hA5A5_0001; sz1 = SZ_W;
        #1; check("l1_s0_wait", 32'(w1), 32'd1);
        @(negedge clk); #1; check("l1_s0_done", 32'(w1), 32'd0);
        check("l1_s0_err", 32'(e1), 32'd0);
        a1 = 32'h4; wd1 = 32'h5A5A_0002;
        @(negedge clk); #1; check("l1_s1_wait", 32'(w1), 32'd1);
        @(negedge clk); #1; check("l1_s1_done", 32'(w1), 32'd0);
        wr1 = 1'b0; rd1 = 1'b1; a1 = 32'h0;
        @(negedge clk); #1; check("l1_l0_wait", 32'(w1), 32'd1);
        @(negedge clk); #1; check("l1_l0_done", 32'(w1), 32'd0);
        check("l1_l0_data", q1, 32'hA5A5_0001);
        a1 = 32'h4;
        @(negedge clk); #1; check("l1_l1_wait", 32'(w1), 32'd1);
        @(negedge clk); #1; check("l1_l1_done", 32'(w1), 32'd0);
        check("l1_l1_data", q1, 32'h5A5A_0002);
        rd1 = 1'b0;
        @(negedge clk); #1;
        check("l1_idle", 32'(w1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
